// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: predictor redirect/stall inputs, instruction memory handshake, IF/ID outputs.
// imem handshake: imem_req is level-sensitive and imem_addr stays stable until imem_ready=1 completes the transfer.
interface fetch_unit_if;
  logic [31:0] pcNext;
  logic        id_flush;
  logic        stall;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  modport master (
    output pcNext, id_flush, stall, imem_ready, imem_data,
    input  pc, imem_req, imem_addr, id_pc, id_inst, id_valid
  );

  modport slave (
    input  pcNext, id_flush, stall, imem_ready, imem_data,
    output pc, imem_req, imem_addr, id_pc, id_inst, id_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register, skid buffer for stalled responses,
// and a redirect register that lets a flushed in-flight request drain before refetching.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.slave  bus,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_inst;
  logic [31:0] r_redirect;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_id_pc_next;
  logic [31:0] w_id_inst_next;
  logic        w_id_valid_next;
  logic [31:0] w_skid_pc_next;
  logic [31:0] w_skid_inst_next;
  logic [31:0] w_redirect_next;
  logic [31:0] w_drain_target;
  logic        w_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_id_pc     <= 32'h0;
      r_id_inst   <= NOP_INST;
      r_id_valid  <= 1'b0;
      r_skid_pc   <= 32'h0;
      r_skid_inst <= 32'h0;
      r_redirect  <= 32'h0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_id_pc     <= w_id_pc_next;
      r_id_inst   <= w_id_inst_next;
      r_id_valid  <= w_id_valid_next;
      r_skid_pc   <= w_skid_pc_next;
      r_skid_inst <= w_skid_inst_next;
      r_redirect  <= w_redirect_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_id_pc_next     = r_id_pc;
    w_id_inst_next   = r_id_inst;
    w_id_valid_next  = r_id_valid;
    w_skid_pc_next   = r_skid_pc;
    w_skid_inst_next = r_skid_inst;
    w_redirect_next  = r_redirect;
    w_drain_target   = bus.id_flush ? bus.pcNext : r_redirect;
    w_req            = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (bus.id_flush) begin
          w_id_valid_next = 1'b0;
          w_id_inst_next  = NOP_INST;
          if (bus.imem_ready) begin
            w_id_pc_next = r_pc;
            w_pc_next    = bus.pcNext;
          end else begin
            // Response still in flight for the wrong path: remember the target and wait it out.
            w_redirect_next = bus.pcNext;
            w_state_next    = S_DRAIN;
          end
        end else if (bus.stall) begin
          if (bus.imem_ready) begin
            w_skid_pc_next   = r_pc;
            w_skid_inst_next = bus.imem_data;
            w_state_next     = S_HOLD;
          end
        end else if (bus.imem_ready) begin
          w_id_pc_next    = r_pc;
          w_id_inst_next  = bus.imem_data;
          w_id_valid_next = 1'b1;
          w_pc_next       = bus.pcNext;
        end else begin
          w_id_valid_next = 1'b0;
          w_id_inst_next  = NOP_INST;
        end
      end

      S_HOLD: begin
        if (bus.id_flush) begin
          w_id_pc_next     = r_pc;
          w_id_inst_next   = NOP_INST;
          w_id_valid_next  = 1'b0;
          w_skid_pc_next   = 32'h0;
          w_skid_inst_next = 32'h0;
          w_pc_next        = bus.pcNext;
          w_state_next     = S_FETCH;
        end else if (!bus.stall) begin
          w_id_pc_next    = r_skid_pc;
          w_id_inst_next  = r_skid_inst;
          w_id_valid_next = 1'b1;
          w_pc_next       = bus.pcNext;
          w_state_next    = S_FETCH;
        end
      end

      S_DRAIN: begin
        w_req           = 1'b1;
        w_id_valid_next = 1'b0;
        if (bus.imem_ready) begin
          // The returning word belongs to the flushed path and is dropped.
          w_pc_next       = w_drain_target;
          w_redirect_next = 32'h0;
          w_state_next    = S_FETCH;
        end else if (bus.id_flush) begin
          w_redirect_next = bus.pcNext;
        end
      end

      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  assign bus.pc        = r_pc;
  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.id_pc     = r_id_pc;
  assign bus.id_inst   = r_id_inst;
  assign bus.id_valid  = r_id_valid;
  assign o_dbg_state   = r_state;

endmodule
